// File: rtl/mvu_job_dispatcher.sv
// mvu_job_dispatcher: round-robin arbiter that snapshots a hart's MVU CSRs into a descriptor,
// issues it to the shared MVU and returns a completion irq to the owning hart.
module mvu_job_dispatcher #(
    parameter int NUM_HARTS = 8,
    parameter int HART_W    = $clog2(NUM_HARTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_HARTS-1:0]    mvu_start,
    input  logic [32*NUM_HARTS-1:0] csr_mvu_wbaseaddr,
    input  logic [32*NUM_HARTS-1:0] csr_mvu_ibaseaddr,
    input  logic [32*NUM_HARTS-1:0] csr_mvu_obaseaddr,
    input  logic [32*NUM_HARTS-1:0] csr_mvu_wstride_0,
    input  logic [32*NUM_HARTS-1:0] csr_mvu_wlength_0,
    input  logic [32*NUM_HARTS-1:0] csr_mvu_precision,
    input  logic [32*NUM_HARTS-1:0] csr_mvu_quant,
    input  logic [32*NUM_HARTS-1:0] csr_mvu_command,
    output logic                    desc_valid,
    input  logic                    desc_ready,
    output logic [HART_W-1:0]       desc_hart,
    output logic [31:0]             desc_wbaseaddr,
    output logic [31:0]             desc_ibaseaddr,
    output logic [31:0]             desc_obaseaddr,
    output logic [31:0]             desc_wstride_0,
    output logic [31:0]             desc_wlength_0,
    output logic [31:0]             desc_precision,
    output logic [31:0]             desc_quant,
    output logic [31:0]             desc_command,
    input  logic                    mvu_done,
    output logic [NUM_HARTS-1:0]    mvu_irq_o,
    output logic [NUM_HARTS-1:0]    hart_busy_o,
    output logic [NUM_HARTS-1:0]    start_drop_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, RUN, IRQ} state_t;

    state_t                 state, state_n;
    logic [NUM_HARTS-1:0]   pending, pending_n, active_mask, drop, grant_mask, busy_n;
    logic [HART_W-1:0]      rr_ptr, grant, idx;
    logic                   grant_en, take;
    logic [255:0]           csr_row [NUM_HARTS];
    logic [255:0]           desc;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_row
        assign csr_row[h] = {csr_mvu_wbaseaddr[32*h +: 32], csr_mvu_ibaseaddr[32*h +: 32],
                             csr_mvu_obaseaddr[32*h +: 32], csr_mvu_wstride_0[32*h +: 32],
                             csr_mvu_wlength_0[32*h +: 32], csr_mvu_precision[32*h +: 32],
                             csr_mvu_quant[32*h +: 32], csr_mvu_command[32*h +: 32]};
    end

    assign {desc_wbaseaddr, desc_ibaseaddr, desc_obaseaddr, desc_wstride_0,
            desc_wlength_0, desc_precision, desc_quant, desc_command} = desc;

    // First pending hart at or after rr_ptr, wrapping at NUM_HARTS
    always_comb begin
        grant    = '0;
        grant_en = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            idx = HART_W'((int'(rr_ptr) + i) % NUM_HARTS);
            if (!grant_en && pending[idx]) begin
                grant    = idx;
                grant_en = 1'b1;
            end
        end
    end

    always_comb begin
        take        = state == IDLE && grant_en;
        active_mask = (state != IDLE) ? NUM_HARTS'(1) << desc_hart : '0;
        drop        = mvu_start & (pending | active_mask);
        grant_mask  = take ? NUM_HARTS'(1) << grant : '0;
        pending_n   = (pending & ~grant_mask) | (mvu_start & ~drop);
        state_n     = take                          ? ISSUE :
                      (state == ISSUE && desc_ready) ? RUN   :
                      (state == RUN && mvu_done)     ? IRQ   :
                      (state == IRQ)                 ? IDLE  : state;
        busy_n      = pending_n | ((state_n != IDLE) ? NUM_HARTS'(1) << (take ? grant : desc_hart) : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            rr_ptr       <= '0;
            desc_hart    <= '0;
            desc         <= '0;
            desc_valid   <= 1'b0;
            mvu_irq_o    <= '0;
            hart_busy_o  <= '0;
            start_drop_o <= '0;
        end else begin
            state        <= state_n;
            pending      <= pending_n;
            desc_valid   <= state_n == ISSUE;
            mvu_irq_o    <= (state == RUN && mvu_done) ? active_mask : '0;
            hart_busy_o  <= busy_n;
            start_drop_o <= drop;
            if (take) begin
                desc_hart <= grant;
                desc      <= csr_row[grant];
                rr_ptr    <= (int'(grant) == NUM_HARTS - 1) ? '0 : grant + 1'b1;
            end
        end
    end
endmodule
